ps2_cmd_sequencer: RTL and testbench

- Sits between the PS2 receiver (byte plus done strobe) and the alarm-panel outputs.
- Sequences the keyboard scancode stream through prefix handling: break prefix F0, extended prefix E0, and their combination.
- Commits only make codes of the seven command keys to registered, state-holding outputs Temp0, Temp1, Humo and Elec.
- Includes an inter-byte timeout so a dropped byte cannot leave the sequencer stuck in a prefix state.

---
 rtl/ps2_cmd_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_cmd_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 scancode sequencer: walks the F0/E0 prefix grammar and commits
// make codes of seven command keys to held alarm-panel outputs.
//
// Ports:
//   clk_rx    - clock, rising edge
//   reset     - async active-low reset
//   rx_done   - one-cycle strobe, rx_data valid
//   rx_data   - received scancode byte
//   Temp0/1   - temperature code bits (held)
//   Humo      - smoke alarm (held)
//   Elec      - electrical alarm (held)
//   cmd_valid - pulse when a command key updates the outputs
//   cmd_code  - last accepted command scancode (held)
//   err       - pulse on protocol error or inter-byte timeout
//
// Optional: define PS2_REPEAT_FILTER_EN to drop typematic repeats of the
// last accepted command make until its break code is seen.
module ps2_cmd_sequencer #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk_rx,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       Temp0,
  output logic       Temp1,
  output logic       Humo,
  output logic       Elec,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;

  logic is_f0;
  logic is_e0;
  logic is_cmd;
  logic tmo;
  logic make_hit;
  logic acc;
  logic rel;
  logic err_nx;
  logic t0_nx;
  logic t1_nx;
  logic humo_nx;
  logic elec_nx;

  assign is_f0 = (rx_data == 8'hF0);
  assign is_e0 = (rx_data == 8'hE0);

  always_comb begin
    unique case (rx_data)
      8'h1C, 8'h1A, 8'h22,
      8'h23, 8'h21,
      8'h2B, 8'h2A: is_cmd = 1'b1;
      default:      is_cmd = 1'b0;
    endcase
  end

  // A strobe in the same cycle as expiry takes priority over the timeout.
  assign tmo = !rx_done && (state != IDLE) && (cnt == CNT_LAST);

  assign make_hit = rx_done && (state == IDLE) && is_cmd;
  assign rel      = rx_done && (state == BRK) && !is_f0 && !is_e0;

`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] last_make;

  assign acc = make_hit && (rx_data != last_make);

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      last_make <= 8'h00;
    end else if (acc) begin
      last_make <= rx_data;
    end else if (rel && (rx_data == last_make)) begin
      last_make <= 8'h00;
    end
  end
`else
  assign acc = make_hit;
`endif

  // State register
  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (rx_done) begin
      unique case (state)
        IDLE: begin
          if (is_f0)      state_nx = BRK;
          else if (is_e0) state_nx = EXT;
          else            state_nx = IDLE;
        end
        BRK: begin
          if (is_f0)      state_nx = BRK;
          else if (is_e0) state_nx = EXT;
          else            state_nx = IDLE;
        end
        EXT: begin
          if (is_f0)      state_nx = EXT_BRK;
          else if (is_e0) state_nx = EXT;
          else            state_nx = IDLE;
        end
        EXT_BRK:          state_nx = IDLE;
      endcase
    end else if (tmo) begin
      state_nx = IDLE;
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    t0_nx   = Temp0;
    t1_nx   = Temp1;
    humo_nx = Humo;
    elec_nx = Elec;
    err_nx  = tmo;
    if (rx_done) begin
      if ((state == BRK) && is_e0)
        err_nx = 1'b1;
      if ((state == EXT_BRK) && (is_e0 || is_f0))
        err_nx = 1'b1;
    end
    if (acc) begin
      unique case (1'b1)
        rx_data == 8'h1C: begin
          t0_nx = 1'b1;
          t1_nx = 1'b1;
        end
        rx_data == 8'h1A: begin
          t0_nx = 1'b0;
          t1_nx = 1'b1;
        end
        rx_data == 8'h22: begin
          t0_nx = 1'b0;
          t1_nx = 1'b0;
        end
        rx_data == 8'h23: humo_nx = 1'b1;
        rx_data == 8'h21: humo_nx = 1'b0;
        rx_data == 8'h2B: elec_nx = 1'b1;
        rx_data == 8'h2A: elec_nx = 1'b0;
        default: ;
      endcase
    end
  end

  // Inter-byte timeout counter; saturates instead of wrapping.
  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (rx_done || tmo || (state == IDLE)) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_rx or negedge reset) begin
    if (!reset) begin
      Temp0     <= 1'b0;
      Temp1     <= 1'b0;
      Humo      <= 1'b0;
      Elec      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'h00;
      err       <= 1'b0;
    end else begin
      Temp0     <= t0_nx;
      Temp1     <= t1_nx;
      Humo      <= humo_nx;
      Elec      <= elec_nx;
      cmd_valid <= acc;
      err       <= err_nx;
      if (acc)
        cmd_code <= rx_data;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Randomised bench for ps2_cmd_sequencer with a prefix-flag reference
// model compared every cycle, plus directed literal checks.
module tb_ps2_cmd_sequencer;

  localparam int TC = 20;

`ifdef PS2_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk_rx = 1'b0;
  logic       reset  = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       Temp0, Temp1, Humo, Elec;
  logic       cmd_valid, err;
  logic [7:0] cmd_code;

  ps2_cmd_sequencer #(
    .TIMEOUT_CYC(TC),
    .CNT_W(5)
  ) dut (
    .clk_rx(clk_rx),
    .reset(reset),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .Temp0(Temp0),
    .Temp1(Temp1),
    .Humo(Humo),
    .Elec(Elec),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .err(err)
  );

  always #5 clk_rx = ~clk_rx;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: prefix state kept as two pending flags.
  logic       m_brk, m_ext;
  logic [7:0] m_last;
  int         m_quiet;
  logic       e_t0, e_t1, e_hu, e_el, e_v, e_err;
  logic [7:0] e_code;

  always @(posedge clk_rx or negedge reset) begin : model
    logic b, x, v, er, t0, t1, hu, el, hit;
    logic [7:0] lm, cd, d;
    int q;
    if (!reset) begin
      m_brk <= 0; m_ext <= 0; m_last <= 0; m_quiet <= 0;
      e_t0 <= 0; e_t1 <= 0; e_hu <= 0; e_el <= 0;
      e_v <= 0; e_err <= 0; e_code <= 0;
    end else begin
      b = m_brk; x = m_ext; lm = m_last; q = m_quiet;
      t0 = e_t0; t1 = e_t1; hu = e_hu; el = e_el; cd = e_code;
      v = 0; er = 0; d = rx_data;
      if (rx_done) begin
        q = 0;
        if (!b && !x) begin
          if (d == 8'hF0) b = 1;
          else if (d == 8'hE0) x = 1;
          else begin
            hit = 1;
            case (d)
              8'h1C: begin t0 = 1; t1 = 1; end
              8'h1A: begin t0 = 0; t1 = 1; end
              8'h22: begin t0 = 0; t1 = 0; end
              8'h23: hu = 1;
              8'h21: hu = 0;
              8'h2B: el = 1;
              8'h2A: el = 0;
              default: hit = 0;
            endcase
            if (hit && FILT && d == lm) begin
              t0 = e_t0; t1 = e_t1; hu = e_hu; el = e_el;
              hit = 0;
            end
            if (hit) begin v = 1; cd = d; lm = d; end
          end
        end else if (b && !x) begin
          if (d == 8'hE0) begin er = 1; b = 0; x = 1; end
          else if (d != 8'hF0) begin
            if (FILT && d == lm) lm = 0;
            b = 0;
          end
        end else if (!b && x) begin
          if (d == 8'hF0) b = 1;
          else if (d != 8'hE0) x = 0;
        end else begin
          if (d == 8'hF0 || d == 8'hE0) er = 1;
          b = 0; x = 0;
        end
      end else if (b || x) begin
        q++;
        if (q == TC) begin b = 0; x = 0; er = 1; q = 0; end
      end
      m_brk <= b; m_ext <= x; m_last <= lm; m_quiet <= q;
      e_t0 <= t0; e_t1 <= t1; e_hu <= hu; e_el <= el;
      e_v <= v; e_err <= er; e_code <= cd;
    end
  end

  always @(negedge clk_rx) begin
    if (cmd_valid === 1'b1) n_valid++;
    if (err === 1'b1) n_err++;
    if (chk_en) begin
      chk("Temp0", {7'd0, Temp0}, {7'd0, e_t0});
      chk("Temp1", {7'd0, Temp1}, {7'd0, e_t1});
      chk("Humo", {7'd0, Humo}, {7'd0, e_hu});
      chk("Elec", {7'd0, Elec}, {7'd0, e_el});
      chk("cmd_valid", {7'd0, cmd_valid}, {7'd0, e_v});
      chk("err", {7'd0, err}, {7'd0, e_err});
      chk("cmd_code", cmd_code, e_code);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk_rx);
    rx_done = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_rx);
    #1;
  endtask

  logic [7:0] pool [0:8];
  int v0, e0;

  initial begin
    pool = '{8'h1C, 8'h1A, 8'h22, 8'h23, 8'h21,
             8'h2B, 8'h2A, 8'hF0, 8'hE0};
    #1 reset = 1'b0;
    idle(2);
    chk("rst_Temp0", {7'd0, Temp0}, 8'd0);
    chk("rst_code", cmd_code, 8'h00);
    chk("rst_valid_err", {6'd0, cmd_valid, err}, 8'd0);
    #1 reset = 1'b1;
    idle(1);
    chk_en = 1'b1;

    send(8'h1C);
    chk("t1_valid", {7'd0, cmd_valid}, 8'd1);
    chk("t1_temps", {6'd0, Temp1, Temp0}, 8'd3);
    chk("t1_code", cmd_code, 8'h1C);
    chk("t1_humo_elec", {6'd0, Humo, Elec}, 8'd0);
    idle(1);
    chk("t1_pulse", {7'd0, cmd_valid}, 8'd0);

    send(8'h23);
    chk("t2_humo", {7'd0, Humo}, 8'd1);
    v0 = n_valid;
    send(8'hF0);
    send(8'h23);
    idle(1);
    chk("t2_break_valid", 8'(n_valid - v0), 8'd0);
    chk("t2_humo_held", {7'd0, Humo}, 8'd1);

    v0 = n_valid; e0 = n_err;
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    idle(1);
    chk("t3_valid", 8'(n_valid - v0), 8'd0);
    chk("t3_err", 8'(n_err - e0), 8'd0);
    chk("t3_temps", {6'd0, Temp1, Temp0}, 8'd3);

    e0 = n_err;
    send(8'hF0);
    idle(TC - 1);
    chk("t4_no_err_early", {7'd0, err}, 8'd0);
    idle(1);
    chk("t4_err", {7'd0, err}, 8'd1);
    idle(1);
    chk("t4_err_once", 8'(n_err - e0), 8'd1);
    send(8'h2B);
    chk("t4_elec", {6'd0, Elec, cmd_valid}, 8'd3);

    send(8'hF0);
    send(8'hE0);
    chk("t5_err", {7'd0, err}, 8'd1);
    v0 = n_valid;
    send(8'h1A);
    idle(1);
    chk("t5_temps", {6'd0, Temp1, Temp0}, 8'd3);
    chk("t5_valid", 8'(n_valid - v0), 8'd0);

    send(8'h23);
    send(8'hF0);
    #1 reset = 1'b0;
    #1;
    chk("rst_async", {4'd0, Temp0, Temp1, Humo, Elec}, 8'd0);
    chk("rst_async_code", cmd_code, 8'h00);
    @(negedge clk_rx);
    #2 reset = 1'b1;
    idle(1);

    v0 = n_valid;
    send(8'h2B); send(8'h2B); send(8'h2B);
    idle(1);
    chk("rep_count", 8'(n_valid - v0), FILT ? 8'd1 : 8'd3);
    v0 = n_valid;
    send(8'hF0); send(8'h2B); send(8'h2B);
    idle(1);
    chk("rep_after_break", 8'(n_valid - v0), 8'd1);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) begin
        if ($urandom_range(0, 3) == 0) send(8'($urandom));
        else send(pool[$urandom_range(0, 8)]);
      end else if (r < 16) idle(1);
      else if (r < 18) begin
        idle(TC - 1);
        send(pool[$urandom_range(0, 8)]);
      end else idle($urandom_range(TC - 3, TC + 3));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
